uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 118 +++++++++++
 tb/tb_uart_tx_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: four-source round-robin arbiter feeding one UART transmitter.
// Each grant optionally sends a channel header byte, then streams up to
// BURST_MAX bytes from the granted source FIFO before re-arbitrating.
module uart_tx_arb #(
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned HDR_EN    = 1
) (
  input  logic        pll_clk,
  input  logic        reset_n,
  input  logic [3:0]  src_empty,
  input  logic [31:0] src_data,
  output logic [3:0]  src_rd,
  output logic        arb_empty,
  output logic [7:0]  arb_data,
  input  logic        uart_par_rd,
  output logic        grant_vld,
  output logic [1:0]  grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] last_grant;
  logic [3:0] byte_cnt;

  logic [1:0] rr_cand;
  logic [1:0] rr_pick;
  logic       rr_hit;
  logic [7:0] sel_data;
  logic       sel_empty;
  logic       burst_last;

  // Round-robin search: first non-empty source after last_grant (wraps to itself last)
  always_comb begin
    rr_cand = '0;
    rr_pick = '0;
    rr_hit  = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      rr_cand = last_grant + k[1:0];
      if (!rr_hit && !src_empty[rr_cand]) begin
        rr_pick = rr_cand;
        rr_hit  = 1'b1;
      end
    end
  end

  // Head byte / empty flag of the currently granted source
  always_comb begin
    sel_data   = src_data[{grant_id, 3'b000} +: 8];
    sel_empty  = src_empty[grant_id];
    burst_last = (({1'b0, byte_cnt} + 5'd1) == 5'(BURST_MAX));
  end

  // UART-side outputs and pop steering, decoded from the registered state/grant
  always_comb begin
    arb_empty = 1'b1;
    arb_data  = '0;
    src_rd    = '0;
    unique case (state)
      HDR: begin
        arb_empty = 1'b0;
        arb_data  = {4'hA, 2'b00, grant_id};
      end
      DATA: begin
        arb_empty        = sel_empty;
        arb_data         = sel_data;
        src_rd[grant_id] = uart_par_rd;
      end
      default: ;
    endcase
  end

  assign grant_vld = (state != IDLE);

  // Arbitration FSM: grant, header, data burst, release
  always_ff @(posedge pll_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      byte_cnt   <= '0;
      grant_id   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rr_hit) begin
            grant_id <= rr_pick;
            byte_cnt <= '0;
            state    <= (HDR_EN != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (uart_par_rd) begin
            byte_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (uart_par_rd) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (burst_last) begin
              state      <= IDLE;
              last_grant <= grant_id;
            end
          end else if (sel_empty) begin
            state      <= IDLE;
            last_grant <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-backed source FIFOs, a UART model that accepts
// on alternate cycles, and a scoreboard of expected bytes checked by a monitor.
module tb_uart_tx_arb;

  logic        pll_clk;
  logic        reset_n;
  logic [3:0]  src_empty;
  logic [31:0] src_data;
  logic [3:0]  src_rd;
  logic        arb_empty;
  logic [7:0]  arb_data;
  logic        uart_par_rd;
  logic        grant_vld;
  logic [1:0]  grant_id;

  uart_tx_arb #(.BURST_MAX(8), .HDR_EN(1)) dut (
    .pll_clk     (pll_clk),
    .reset_n     (reset_n),
    .src_empty   (src_empty),
    .src_data    (src_data),
    .src_rd      (src_rd),
    .arb_empty   (arb_empty),
    .arb_data    (arb_data),
    .uart_par_rd (uart_par_rd),
    .grant_vld   (grant_vld),
    .grant_id    (grant_id)
  );

  initial pll_clk = 1'b0;
  always #5 pll_clk = ~pll_clk;

  typedef struct {
    logic [7:0] b;
    logic [3:0] rd;
    logic [1:0] gid;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] srcq[4][$];
  int         pop_cnt[4];
  int         tests = 0;
  int         fails = 0;
  logic       uart_auto;
  logic       force_rd;
  logic       phase;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_hdr(input int g);
    exp_t e;
    e.b = 8'hA0 | 8'(g);
    e.rd = 4'b0000;
    e.gid = 2'(g);
    expq.push_back(e);
  endtask

  task automatic push_data(input int g, input logic [7:0] b);
    exp_t e;
    e.b = b;
    e.rd = 4'b0001 << g;
    e.gid = 2'(g);
    expq.push_back(e);
  endtask

  // One clock: present FIFO heads, decide UART accept, then pop what the DUT read
  task automatic step();
    @(negedge pll_clk);
    for (int i = 0; i < 4; i++) begin
      src_empty[i] = (srcq[i].size() == 0);
      src_data[i*8 +: 8] = (srcq[i].size() == 0) ? 8'h00 : srcq[i][0];
    end
    #1;
    uart_par_rd = force_rd | (uart_auto & ~arb_empty & phase);
    phase = ~phase;
    #3;
    for (int i = 0; i < 4; i++) begin
      if (src_rd[i] && srcq[i].size() != 0) begin
        void'(srcq[i].pop_front());
        pop_cnt[i]++;
      end
    end
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(expq.size() == 0 && !grant_vld) && n < budget);
    if (!(expq.size() == 0 && !grant_vld)) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending want 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_arb_empty"}, 32'(arb_empty), 32'd1);
    check({name, "_arb_data"},  32'(arb_data),  32'h00);
    check({name, "_src_rd"},    32'(src_rd),    32'h0);
    check({name, "_grant_vld"}, 32'(grant_vld), 32'd0);
  endtask

  // Monitor: every UART accept is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge pll_clk);
      #2;
      if (reset_n && uart_par_rd) begin
        if (!grant_vld) begin
          check("idle_rd_no_pop", 32'(src_rd), 32'h0);
        end else if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h want none", arb_data);
        end else begin
          e = expq.pop_front();
          check("uart_byte", 32'(arb_data), 32'(e.b));
          check("src_rd",    32'(src_rd),   32'(e.rd));
          check("grant_id",  32'(grant_id), 32'(e.gid));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    uart_par_rd = 1'b0;
    src_empty = '1;
    src_data = '0;
    uart_auto = 1'b1;
    force_rd = 1'b0;
    phase = 1'b0;
    for (int i = 0; i < 4; i++) pop_cnt[i] = 0;

    // Reset with every source non-empty
    for (int g = 0; g < 4; g++) srcq[g].push_back(8'hF0 | 8'(g));
    step();
    step();
    check_idle("reset");
    check("reset_grant_id", 32'(grant_id), 32'd0);
    for (int g = 0; g < 4; g++) srcq[g].delete();
    step();
    reset_n = 1'b1;

    // Single source with header
    srcq[0].push_back(8'h11);
    srcq[0].push_back(8'h22);
    srcq[0].push_back(8'h33);
    push_hdr(0);
    push_data(0, 8'h11);
    push_data(0, 8'h22);
    push_data(0, 8'h33);
    run_until_done("single", 200);
    check("single_pops", 32'(pop_cnt[0]), 32'd3);
    check_idle("single_idle");

    // Fresh reset so the fairness run starts at src0
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;

    // Fairness: 10 bytes everywhere -> 8-byte bursts then 2-byte bursts
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 10; k++) srcq[g].push_back(8'((g << 4) | k));
    for (int g = 0; g < 4; g++) begin
      push_hdr(g);
      for (int k = 0; k < 8; k++) push_data(g, 8'((g << 4) | k));
    end
    for (int g = 0; g < 4; g++) begin
      push_hdr(g);
      for (int k = 8; k < 10; k++) push_data(g, 8'((g << 4) | k));
    end
    run_until_done("fair", 2000);
    check_idle("fair_idle");

    // Round-robin skip: make last_grant=2, then src0 and src2 compete -> src0
    srcq[2].push_back(8'h55);
    push_hdr(2);
    push_data(2, 8'h55);
    run_until_done("skip_prep", 200);
    srcq[0].push_back(8'h66);
    srcq[2].push_back(8'h77);
    push_hdr(0);
    push_data(0, 8'h66);
    push_hdr(2);
    push_data(2, 8'h77);
    run_until_done("skip", 200);

    // Early empty on src1, then last_grant=1 means src2,src0,src1 order
    pop_cnt[1] = 0;
    srcq[1].push_back(8'h88);
    srcq[1].push_back(8'h99);
    push_hdr(1);
    push_data(1, 8'h88);
    push_data(1, 8'h99);
    run_until_done("early", 200);
    check("early_pops", 32'(pop_cnt[1]), 32'd2);
    srcq[0].push_back(8'hE5);
    srcq[1].push_back(8'hE3);
    srcq[2].push_back(8'hE4);
    push_hdr(2);
    push_data(2, 8'hE4);
    push_hdr(0);
    push_data(0, 8'hE5);
    push_hdr(1);
    push_data(1, 8'hE3);
    run_until_done("after_early", 300);

    // Spurious accepts while idle
    uart_auto = 1'b0;
    force_rd = 1'b1;
    repeat (3) step();
    force_rd = 1'b0;
    uart_auto = 1'b1;
    step();
    check_idle("spurious");

    // Reset in the middle of a src2 burst
    pop_cnt[2] = 0;
    for (int k = 1; k <= 6; k++) srcq[2].push_back(8'hC0 | 8'(k));
    push_hdr(2);
    for (int k = 1; k <= 3; k++) push_data(2, 8'hC0 | 8'(k));
    for (int n = 0; n < 200 && pop_cnt[2] < 3; n++) step();
    check("mid_pops", 32'(pop_cnt[2]), 32'd3);
    uart_auto = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check_idle("mid_reset");
    srcq[0].push_back(8'hD1);
    srcq[0].push_back(8'hD2);
    step();
    check_idle("mid_reset_hold");
    reset_n = 1'b1;
    uart_auto = 1'b1;
    push_hdr(0);
    push_data(0, 8'hD1);
    push_data(0, 8'hD2);
    push_hdr(2);
    for (int k = 4; k <= 6; k++) push_data(2, 8'hC0 | 8'(k));
    run_until_done("after_reset", 300);
    check_idle("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
